// File: rtl/cpu_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_if
// Bundles the host-side controls and the core-side handshake of the run-control
// sequencer.
//   master : the sequencer (drives core_rst, core_pc_load, core_pc, core_run,
//            flush_req, done, busy, cycle_count)
//   slave  : the memory map and core (drive go, start_addr, reset, unhalt,
//            core_halt, core_bkpt, flush_ack)
// -----------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int CNT_WIDTH  = 32
);
   // host controls from the memory map
   logic                  go;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic                  reset;
   logic                  unhalt;
   // status from the core / cache
   logic                  core_halt;
   logic                  core_bkpt;
   logic                  flush_ack;
   // sequencer outputs
   logic                  core_rst;
   logic                  core_pc_load;
   logic [ADDR_WIDTH-1:0] core_pc;
   logic                  core_run;
   logic                  flush_req;
   logic                  done;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  cycle_count;

   modport master (
      input  go, start_addr, reset, unhalt, core_halt, core_bkpt, flush_ack,
      output core_rst, core_pc_load, core_pc, core_run, flush_req, done, busy,
             cycle_count
   );

   modport slave (
      output go, start_addr, reset, unhalt, core_halt, core_bkpt, flush_ack,
      input  core_rst, core_pc_load, core_pc, core_run, flush_req, done, busy,
             cycle_count
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run-control sequencer between the MMIO memory map and the processor core.
// Turns a host go pulse into: core reset (RST_CYCLES cycles), PC load strobe,
// run, optional breakpoint pause, cache flush and a sticky done indication.
// Counts the cycles spent in RUN (saturating) for host readback.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : cpu_run_ctrl_if.master (host controls, core handshake, status)
// All outputs are flops loaded from next-state decode, so no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int ADDR_WIDTH = 64,
   parameter int RST_CYCLES = 4,
   parameter int CNT_WIDTH  = 32
) (
   input logic            clk,
   input logic            rst,
   cpu_run_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_PAUSE = 3'd4,
      S_FLUSH = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [7:0]           RCNT_LOAD = 8'(RST_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t                state_q, state_d, state_nxt;
   logic [7:0]            rcnt_q, rcnt_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  unhalt_q, unhalt_d;
   logic                  core_rst_q, core_rst_d;
   logic                  pc_load_q, pc_load_d;
   logic                  run_q, run_d;
   logic                  flush_q, flush_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  go_accept;
   logic                  unhalt_rise;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_nxt = state_q;
      rcnt_d    = rcnt_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      unhalt_d  = bus.unhalt;

      // go is only honoured when idle/done and never alongside an abort
      go_accept   = bus.go & ~bus.reset &
                    ((state_q == S_IDLE) | (state_q == S_DONE));
      unhalt_rise = bus.unhalt & ~unhalt_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (go_accept) begin
               state_nxt = S_RESET;
               pc_d      = bus.start_addr;
               cnt_d     = '0;
               rcnt_d    = RCNT_LOAD;
            end else begin
               state_nxt = state_q;
            end
         end
         S_RESET: begin
            if (rcnt_q == 8'd0) begin
               state_nxt = S_LOAD;
            end else begin
               rcnt_d = rcnt_q - 8'd1;
            end
         end
         S_LOAD: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            // every edge spent in RUN counts, including the exit edge
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
            if (bus.core_halt) begin
               state_nxt = S_FLUSH;
            end else if (bus.core_bkpt) begin
               state_nxt = S_PAUSE;
            end else begin
               state_nxt = S_RUN;
            end
         end
         S_PAUSE: begin
            // a level unhalt left high from before the pause has no edge here
            if (unhalt_rise) begin
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_PAUSE;
            end
         end
         S_FLUSH: begin
            if (bus.flush_ack) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_FLUSH;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // host abort overrides every other transition
      state_d = bus.reset ? S_IDLE : state_nxt;

      core_rst_d = (state_d == S_IDLE) | (state_d == S_RESET);
      pc_load_d  = (state_d == S_LOAD);
      run_d      = (state_d == S_RUN);
      flush_d    = (state_d == S_FLUSH);
      done_d     = (state_d == S_DONE);
      busy_d     = ~((state_d == S_IDLE) | (state_d == S_DONE));
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rcnt_q     <= 8'd0;
         pc_q       <= '0;
         cnt_q      <= '0;
         unhalt_q   <= 1'b0;
         core_rst_q <= 1'b1;
         pc_load_q  <= 1'b0;
         run_q      <= 1'b0;
         flush_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rcnt_q     <= rcnt_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         unhalt_q   <= unhalt_d;
         core_rst_q <= core_rst_d;
         pc_load_q  <= pc_load_d;
         run_q      <= run_d;
         flush_q    <= flush_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.core_rst     = core_rst_q;
   assign bus.core_pc_load = pc_load_q;
   assign bus.core_pc      = pc_q;
   assign bus.core_run     = run_q;
   assign bus.flush_req    = flush_q;
   assign bus.done         = done_q;
   assign bus.busy         = busy_q;
   assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Table-driven bench for cpu_run_ctrl (RST_CYCLES=4, CNT_WIDTH=4 so that
// saturation is reachable). Each record holds the inputs for one or more edges
// and the outputs expected after each of those edges; expectations are queued
// when the inputs are driven and compared by a monitor just after the edge.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

   localparam int AW = 64;
   localparam int RC = 4;
   localparam int CW = 4;
   localparam bit L  = 1'b0;
   localparam bit H  = 1'b1;

   typedef enum int {E_IDLE, E_RESET, E_LOAD, E_RUN, E_PAUSE, E_FLUSH, E_DONE} est_t;

   typedef struct {
      int          reps;
      bit          go;
      logic [63:0] addr;
      bit          rs;
      bit          uh;
      bit          hl;
      bit          bk;
      bit          ak;
      est_t        st;
      logic [63:0] pc;
      int          cnt;
      bit          up;
   } vec_t;

   typedef struct {
      string       tag;
      logic [5:0]  fl;
      logic [63:0] pc;
      logic [3:0]  cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;
   int   vidx;
   exp_t sb[$];
   exp_t em;
   vec_t tbl[$];

   cpu_run_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   cpu_run_ctrl #(.ADDR_WIDTH(AW), .RST_CYCLES(RC), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected {core_rst, core_pc_load, core_run, flush_req, done, busy}
   function automatic logic [5:0] flags(input est_t s);
      case (s)
         E_IDLE:  return 6'b100000;
         E_RESET: return 6'b100001;
         E_LOAD:  return 6'b010001;
         E_RUN:   return 6'b001001;
         E_PAUSE: return 6'b000001;
         E_FLUSH: return 6'b000101;
         E_DONE:  return 6'b000010;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic vec_t mkv(input int reps, input bit go, input logic [63:0] addr,
                                input bit rs, input bit uh, input bit hl, input bit bk,
                                input bit ak, input est_t st, input logic [63:0] pc,
                                input int cnt, input bit up);
      vec_t v;
      v.reps = reps; v.go = go; v.addr = addr; v.rs = rs; v.uh = uh;
      v.hl = hl; v.bk = bk; v.ak = ak; v.st = st; v.pc = pc; v.cnt = cnt; v.up = up;
      return v;
   endfunction

   task automatic chk(input string tag, input string fld, input logic [63:0] got,
                      input logic [63:0] want);
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s %s: got %0h, want %0h", tag, fld, got, want);
      end
   endtask

   // Drive one record; queue one expectation per edge it covers
   task automatic apply(input vec_t v);
      exp_t e;
      int   c;
      for (int r = 0; r < v.reps; r++) begin
         @(negedge clk);
         bus.go         = v.go;
         bus.start_addr = v.addr;
         bus.reset      = v.rs;
         bus.unhalt     = v.uh;
         bus.core_halt  = v.hl;
         bus.core_bkpt  = v.bk;
         bus.flush_ack  = v.ak;
         c = v.up ? (v.cnt + r) : v.cnt;
         if (c > 15) c = 15;
         e.tag = $sformatf("v%0d.%0d", vidx, r);
         e.fl  = flags(v.st);
         e.pc  = v.pc;
         e.cnt = 4'(c);
         sb.push_back(e);
      end
      vidx++;
   endtask

   // go pulse followed by the fixed RESET/LOAD/first-RUN sequence
   task automatic startup(input logic [63:0] a, input bit uh);
      apply(mkv(1, H, a, L, uh, L, L, L, E_RESET, a, 0, L));
      apply(mkv(3, L, 64'h0, L, uh, L, L, L, E_RESET, a, 0, L));
      apply(mkv(1, L, 64'h0, L, uh, L, L, L, E_LOAD, a, 0, L));
      apply(mkv(1, L, 64'h0, L, uh, L, L, L, E_RUN, a, 0, L));
   endtask

   // Scoreboard monitor: compare just after each rising edge
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         em = sb.pop_front();
         n_vec++;
         chk(em.tag, "core_rst",     64'(bus.core_rst),     64'(em.fl[5]));
         chk(em.tag, "core_pc_load", 64'(bus.core_pc_load), 64'(em.fl[4]));
         chk(em.tag, "core_run",     64'(bus.core_run),     64'(em.fl[3]));
         chk(em.tag, "flush_req",    64'(bus.flush_req),    64'(em.fl[2]));
         chk(em.tag, "done",         64'(bus.done),         64'(em.fl[1]));
         chk(em.tag, "busy",         64'(bus.busy),         64'(em.fl[0]));
         chk(em.tag, "core_pc",      bus.core_pc,           em.pc);
         chk(em.tag, "cycle_count",  64'(bus.cycle_count),  64'(em.cnt));
      end
   end

   initial begin
      n_vec = 0; n_miss = 0; vidx = 0;
      rst = 1'b1;
      bus.go = 1'b0; bus.start_addr = 64'h0; bus.reset = 1'b0; bus.unhalt = 1'b0;
      bus.core_halt = 1'b0; bus.core_bkpt = 1'b0; bus.flush_ack = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // basic run, stray flush_ack, go while busy, restart, priority, saturation
      tbl.push_back(mkv(2, L, 64'h0,    L, L, L, L, L, E_IDLE,  64'h0,    0,  L));
      tbl.push_back(mkv(1, H, 64'h1000, L, L, L, L, L, E_RESET, 64'h1000, 0,  L));
      tbl.push_back(mkv(3, L, 64'h0,    L, L, L, L, L, E_RESET, 64'h1000, 0,  L));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, L, E_LOAD,  64'h1000, 0,  L));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, L, E_RUN,   64'h1000, 0,  L));
      tbl.push_back(mkv(3, L, 64'h0,    L, L, L, L, L, E_RUN,   64'h1000, 1,  H));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, H, E_RUN,   64'h1000, 4,  L));
      tbl.push_back(mkv(1, H, 64'h2000, L, L, L, L, L, E_RUN,   64'h1000, 5,  L));
      tbl.push_back(mkv(4, L, 64'h0,    L, L, L, L, L, E_RUN,   64'h1000, 6,  H));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, H, L, L, E_FLUSH, 64'h1000, 10, L));
      tbl.push_back(mkv(2, L, 64'h0,    L, L, H, L, L, E_FLUSH, 64'h1000, 10, L));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, H, E_DONE,  64'h1000, 10, L));
      tbl.push_back(mkv(3, L, 64'h0,    L, L, L, L, L, E_DONE,  64'h1000, 10, L));
      tbl.push_back(mkv(1, H, 64'h3000, L, L, L, L, L, E_RESET, 64'h3000, 0,  L));
      tbl.push_back(mkv(3, L, 64'h0,    L, L, L, L, L, E_RESET, 64'h3000, 0,  L));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, L, E_LOAD,  64'h3000, 0,  L));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, L, E_RUN,   64'h3000, 0,  L));
      tbl.push_back(mkv(20, L, 64'h0,   L, L, L, L, L, E_RUN,   64'h3000, 1,  H));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, H, H, L, E_FLUSH, 64'h3000, 15, L));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, H, E_DONE,  64'h3000, 15, L));
      tbl.push_back(mkv(1, L, 64'h0,    H, L, L, L, L, E_IDLE,  64'h3000, 15, L));
      tbl.push_back(mkv(1, L, 64'h0,    L, L, L, L, L, E_IDLE,  64'h3000, 15, L));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
      end

      // breakpoint: unhalt level held into PAUSE must not resume; a fresh rise does
      startup(64'h4000, L);
      apply(mkv(4, L, 64'h0, L, H, L, L, L, E_RUN,   64'h4000, 1, H));
      apply(mkv(1, L, 64'h0, L, H, L, H, L, E_PAUSE, 64'h4000, 5, L));
      apply(mkv(3, L, 64'h0, L, H, L, H, L, E_PAUSE, 64'h4000, 5, L));
      apply(mkv(1, L, 64'h0, L, L, L, H, L, E_PAUSE, 64'h4000, 5, L));
      apply(mkv(1, L, 64'h0, L, H, L, L, L, E_RUN,   64'h4000, 5, L));
      apply(mkv(2, L, 64'h0, L, H, L, L, L, E_RUN,   64'h4000, 6, H));
      apply(mkv(1, L, 64'h0, L, H, H, L, L, E_FLUSH, 64'h4000, 8, L));
      apply(mkv(1, L, 64'h0, L, L, L, L, H, E_DONE,  64'h4000, 8, L));

      // abort during RUN, then go+reset together stays IDLE
      startup(64'h5000, L);
      apply(mkv(2, L, 64'h0,    L, L, L, L, L, E_RUN,  64'h5000, 1, H));
      apply(mkv(1, L, 64'h0,    H, L, L, L, L, E_IDLE, 64'h5000, 3, L));
      apply(mkv(2, H, 64'h6000, H, L, L, L, L, E_IDLE, 64'h5000, 3, L));

      // abort during FLUSH wins over a same-cycle flush_ack; later ack ignored
      startup(64'h6000, L);
      apply(mkv(1, L, 64'h0, L, L, H, L, L, E_FLUSH, 64'h6000, 1, L));
      apply(mkv(1, L, 64'h0, L, L, L, L, L, E_FLUSH, 64'h6000, 1, L));
      apply(mkv(1, L, 64'h0, H, L, L, L, H, E_IDLE,  64'h6000, 1, L));
      apply(mkv(1, L, 64'h0, L, L, L, L, H, E_IDLE,  64'h6000, 1, L));

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer between the MMIO memory map and the processor core. It converts the host's `go`, `reset` and `unhalt` controls plus `start_addr` into a sequence of core reset, PC load, run, breakpoint pause, cache flush and completion. It returns `done` to the memory map and keeps a run-cycle counter for host readback.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, width of `start_addr` and `core_pc`.
- `RST_CYCLES`, 4, cycles `core_rst` is held after `go`; legal range 1..255.
- `CNT_WIDTH`, 32, width of `cycle_count`.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `go` in 1: one-cycle start pulse from the memory map.
- `start_addr` in ADDR_WIDTH: program entry PC; sampled on an accepted `go`.
- `reset` in 1: host abort level from the memory map.
- `unhalt` in 1: host resume level from the memory map; resume acts on its rising edge.
- `core_halt` in 1: core has retired a HALT instruction; level input.
- `core_bkpt` in 1: core has stopped at a breakpoint; level input.
- `flush_ack` in 1: cache writeback has completed; one-cycle pulse.
- `core_rst` out 1: reset to the core pipeline.
- `core_pc_load` out 1: one-cycle load strobe for `core_pc`.
- `core_pc` out ADDR_WIDTH: registered entry PC.
- `core_run` out 1: core enable; 0 stalls the core.
- `flush_req` out 1: request a cache writeback.
- `done` out 1: run complete; level output to the memory map.
- `busy` out 1: high in every state except IDLE and DONE.
- `cycle_count` out CNT_WIDTH: number of cycles spent in RUN.

## Operation
States are IDLE, RESET, LOAD, RUN, PAUSE, FLUSH and DONE.

- **IDLE**: `core_rst`=1, all other control outputs 0.
  - `go` → RESET. On this cycle: latch `start_addr` into `core_pc`, clear `cycle_count`, load the reset counter with RST_CYCLES-1.
- **RESET**: `core_rst`=1. The counter decrements each cycle; at 0 → LOAD. `core_rst` is therefore high for exactly RST_CYCLES cycles in RESET.
- **LOAD**: `core_pc_load`=1, `core_rst`=0. Lasts one cycle, then → RUN.
- **RUN**: `core_run`=1; `cycle_count` increments each cycle and saturates at all-ones.
  - `core_halt` → FLUSH.
  - `core_bkpt` → PAUSE.
  - `core_halt` has priority over `core_bkpt`.
- **PAUSE**: `core_run`=0; `cycle_count` holds.
  - A rising edge of `unhalt` (`unhalt` & ~`unhalt_q`, where `unhalt_q` is registered every cycle) → RUN.
  - A level `unhalt` held from before entering PAUSE does not resume the core.
- **FLUSH**: `flush_req`=1 held until `flush_ack`; then → DONE. A `flush_ack` arriving in any other state is ignored.
- **DONE**: `done`=1, `core_run`=0, `core_rst`=0. Core architectural state is preserved for host inspection.
  - `go` → RESET, behaving as in IDLE; `done` drops in the cycle after `go`.
- **`go` while `busy`**: ignored. `core_pc` and `cycle_count` are unchanged.
- **`reset` high in any state**: → IDLE on the next edge, aborting the run. `flush_req` drops and `done` clears. `reset` has priority over `go` and over every other transition. While `reset` stays high, the block remains in IDLE and `go` is ignored.
- **`rst`**: state=IDLE, `core_pc`=0, `cycle_count`=0, `unhalt_q`=0, reset counter=0. Output values under `rst`: `core_rst`=1, `core_run`=0, `core_pc_load`=0, `flush_req`=0, `done`=0, `busy`=0.

## Timing
- All outputs are registered, or decoded from the state register only. No combinational path runs from any input to any output.
- Counting from `go` high at edge 0:
  - RESET occupies edges 1..RST_CYCLES.
  - `core_pc_load` is high during the cycle after edge RST_CYCLES.
  - `core_run` first goes high one cycle later.
- `core_halt` sampled high at edge N: `core_run`=0 and `flush_req`=1 from edge N+1.
- `flush_ack` sampled at edge M: `flush_req`=0 and `done`=1 from edge M+1.
- `cycle_count` equals the number of edges at which the state was RUN, including the edge that exits RUN.
- A PAUSE→RUN resume takes exactly one cycle after the `unhalt` rising edge is sampled.

## Test plan
- **Basic run**: `start_addr`=0x1000, `go` pulse, RST_CYCLES=4; `core_halt` raised 10 cycles after `core_run` rises; `flush_ack` 3 cycles later. Required: `core_rst` high for 4 cycles, `core_pc`=0x1000 with a 1-cycle `core_pc_load`, `cycle_count`=10, then `done`=1 held.
- **Breakpoint**: `core_bkpt` after 5 run cycles; `unhalt` already high → core stays paused. Drop `unhalt`, raise it again → `core_run` returns 1 cycle later. Halt after 3 more cycles → `cycle_count`=8.
- **Abort**: raise `reset` during RUN, then during FLUSH. Required: IDLE next cycle, `flush_req`=0, `core_rst`=1, `done`=0. Same-cycle `go`+`reset` → stays IDLE.
- **`go` while busy**: second `go` with `start_addr`=0x2000 during RUN → `core_pc` remains 0x1000 and `cycle_count` is not cleared.
- **Restart from DONE**: `go` with `start_addr`=0x3000 → `done`=0 the next cycle, full reset/load sequence, `cycle_count` restarts from 0.
- **Priority and saturation**: `core_halt` and `core_bkpt` raised in the same cycle → FLUSH, not PAUSE. With CNT_WIDTH=4 and 20 run cycles → `cycle_count`=15.
